// File: rtl/alu_share_ctrl_pkg.sv
// Shared encodings for the ALU sharing controller: FSM states, ALU operation
// selects and branch-compare selects.
package alu_share_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // ALUC: 11xx arithmetic, 10xx bitwise, 01xx shifts, 00xx yields zero
  localparam logic [3:0] ALU_ADD = 4'b1100;
  localparam logic [3:0] ALU_SUB = 4'b1101;
  localparam logic [3:0] ALU_AND = 4'b1000;
  localparam logic [3:0] ALU_OR  = 4'b1001;
  localparam logic [3:0] ALU_XOR = 4'b1010;
  localparam logic [3:0] ALU_NOR = 4'b1011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SRA = 4'b0110;
  localparam logic [3:0] ALU_ROL = 4'b0111;

  localparam logic [1:0] ALUB_EQ = 2'b00;
  localparam logic [1:0] ALUB_NE = 2'b01;
  localparam logic [1:0] ALUB_LT = 2'b10;
  localparam logic [1:0] ALUB_GE = 2'b11;

endpackage

// File: rtl/alu_share_ctrl_rr_arb_2.sv
// Two-way round-robin arbiter: when both request, ptr chooses the winner;
// a lone requester always wins. Output is one-hot or zero.
module rr_arb_2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external combinational ALU between two requesters: accept one op,
// drive registered operands, capture the result, return it on a response channel.
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [3:0]       req_aluc0,
  input  logic [3:0]       req_aluc1,
  input  logic [1:0]       req_alub0,
  input  logic [1:0]       req_alub1,
  input  logic             req_unsig0,
  input  logic             req_unsig1,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_aluc,
  output logic [1:0]       alu_alub,
  output logic             alu_unsig,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_check,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_out,
  output logic             rsp_check,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]       aluc_q, aluc_d;
  logic [1:0]       alub_q, alub_d;
  logic             unsig_q, unsig_d;
  logic [WIDTH-1:0] rsp_out_q, rsp_out_d;
  logic             rsp_check_q, rsp_check_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       grant;
  logic             sel;

  rr_arb_2 u_arb (
    .valid (req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  assign sel = grant[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      aluc_q      <= '0;
      alub_q      <= '0;
      unsig_q     <= 1'b0;
      rsp_out_q   <= '0;
      rsp_check_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      a_q         <= a_d;
      b_q         <= b_d;
      aluc_q      <= aluc_d;
      alub_q      <= alub_d;
      unsig_q     <= unsig_d;
      rsp_out_q   <= rsp_out_d;
      rsp_check_q <= rsp_check_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    a_d         = a_q;
    b_d         = b_q;
    aluc_d      = aluc_q;
    alub_d      = alub_q;
    unsig_d     = unsig_q;
    rsp_out_d   = rsp_out_q;
    rsp_check_d = rsp_check_q;
    cnt_d       = cnt_q;
    req_ready   = 2'b00;
    rsp_valid   = 2'b00;
    case (state_q)
      ST_IDLE: begin
        req_ready = grant;
        if (|grant) begin
          owner_d = sel;
          a_d     = sel ? req_a1     : req_a0;
          b_d     = sel ? req_b1     : req_b0;
          aluc_d  = sel ? req_aluc1  : req_aluc0;
          alub_d  = sel ? req_alub1  : req_alub0;
          unsig_d = sel ? req_unsig1 : req_unsig0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_out_d   = alu_out;
        rsp_check_d = alu_check;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = owner_q ? 2'b10 : 2'b01;
        // Only the owner's ready completes the handshake
        if (rsp_ready[owner_q]) begin
          state_d = ST_IDLE;
          ptr_d   = ~owner_q;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_aluc  = aluc_q;
  assign alu_alub  = alub_q;
  assign alu_unsig = unsig_q;
  assign rsp_out   = rsp_out_q;
  assign rsp_check = rsp_check_q;
  assign busy      = (state_q != ST_IDLE);
  assign op_count  = cnt_q;

endmodule
